// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module   : reg_file
// Purpose  : 2^ADDR_WIDTH x DATA_WIDTH register file, two combinational read
//            ports, one synchronous write port, x0 hardwired to zero.
//            Optional write-through bypass: define REG_FILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic                  reg_write,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam int c_NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem_q [c_NUM_REGS];
    logic [DATA_WIDTH-1:0] w_mem_d [c_NUM_REGS];
    logic                  w_wr_en;

    assign w_wr_en = reg_write && (rd != '0);

    always_comb begin
        for (int i = 0; i < c_NUM_REGS; i++) begin
            w_mem_d[i] = r_mem_q[i];
            if (w_wr_en && (rd == ADDR_WIDTH'(i))) begin
                w_mem_d[i] = write_data;
            end
        end
        // Entry 0 never stores anything.
        w_mem_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_mem_q[i] <= w_mem_d[i];
            end
        end
    end

`ifdef REG_FILE_BYPASS_EN
    logic w_byp1;
    logic w_byp2;

    assign w_byp1 = w_wr_en && !reset && (rs1 == rd);
    assign w_byp2 = w_wr_en && !reset && (rs2 == rd);

    assign read_data1 = (rs1 == '0) ? '0 : (w_byp1 ? write_data : r_mem_q[rs1]);
    assign read_data2 = (rs2 == '0) ? '0 : (w_byp2 ? write_data : r_mem_q[rs2]);
`else
    // The x0 compare keeps index 0 at zero even before the first reset.
    assign read_data1 = (rs1 == '0) ? '0 : r_mem_q[rs1];
    assign read_data2 = (rs2 == '0) ? '0 : r_mem_q[rs2];
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file
// Purpose  : Self-checking bench for reg_file: vector table, corner-case
//            sequences and randomized traffic against an array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    logic        clk;
    logic        reset;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic [31:0] write_data;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model [32];

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs [10];

    reg_file #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .reg_write (reg_write),
        .write_data(write_data),
        .read_data1(read_data1),
        .read_data2(read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model update uses the inputs as they stand at the coming edge.
    task automatic tick();
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (reg_write && rd != 5'd0) begin
            model[rd] = write_data;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
        if (!reset && reg_write && rd != 5'd0 && idx == rd) return write_data;
`endif
        return model[idx];
    endfunction

    initial begin
        vecs[0] = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'h0,        32'h0};
        vecs[1] = '{1'b0, 1'b1, 5'd3,  32'h00000007, 5'd3,  5'd0,  32'h00000007, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 5'd4,  32'hFFFFFFF9, 5'd3,  5'd4,  32'h00000007, 32'hFFFFFFF9};
        vecs[3] = '{1'b0, 1'b1, 5'd0,  32'h12345678, 5'd0,  5'd3,  32'h0,        32'h00000007};
        vecs[4] = '{1'b0, 1'b1, 5'd9,  32'h00000011, 5'd9,  5'd4,  32'h00000011, 32'hFFFFFFF9};
        vecs[5] = '{1'b0, 1'b0, 5'd9,  32'h00000022, 5'd9,  5'd9,  32'h00000011, 32'h00000011};
        vecs[6] = '{1'b0, 1'b1, 5'd10, 32'h00000055, 5'd10, 5'd9,  32'h00000055, 32'h00000011};
        vecs[7] = '{1'b1, 1'b1, 5'd10, 32'h00000055, 5'd10, 5'd3,  32'h0,        32'h0};
        vecs[8] = '{1'b0, 1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd31, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[9] = '{1'b0, 1'b1, 5'd31, 32'h5A5A5A5A, 5'd31, 5'd1,  32'h5A5A5A5A, 32'h0};

        reset = 1'b1; reg_write = 1'b0; rd = 5'd0; write_data = 32'h0;
        rs1 = 5'd0; rs2 = 5'd0;
        for (int i = 0; i < 32; i++) model[i] = 32'hX;
        tick();
        reset = 1'b0;

        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i); rs2 = 5'(31 - i);
            #1;
            check($sformatf("reset_rd1[%0d]", i), read_data1, 32'h0);
            check($sformatf("reset_rd2[%0d]", 31 - i), read_data2, 32'h0);
        end

        // Vector table: inputs for one edge, then a read after it.
        for (int v = 0; v < 10; v++) begin
            reset = vecs[v].rst; reg_write = vecs[v].we;
            rd = vecs[v].rd; write_data = vecs[v].wd;
            tick();
            reset = 1'b0; reg_write = 1'b0;
            rs1 = vecs[v].rs1; rs2 = vecs[v].rs2;
            #1;
            check($sformatf("vec%0d_rd1", v), read_data1, vecs[v].e1);
            check($sformatf("vec%0d_rd2", v), read_data2, vecs[v].e2);
        end

        // Preload x5 then reset: everything reads zero.
        reg_write = 1'b1; rd = 5'd5; write_data = 32'hDEADBEEF;
        tick();
        reg_write = 1'b0; rs1 = 5'd5;
        #1;
        check("preload_x5", read_data1, 32'hDEADBEEF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i); rs2 = 5'(i);
            #1;
            check($sformatf("rst2_rd1[%0d]", i), read_data1, 32'h0);
            check($sformatf("rst2_rd2[%0d]", i), read_data2, 32'h0);
        end

        // Same-cycle read/write of x6.
        reg_write = 1'b1; rd = 5'd6; write_data = 32'hAAAA0000;
        tick();
        write_data = 32'h0000BBBB; rs1 = 5'd6; rs2 = 5'd6;
        #1;
`ifdef REG_FILE_BYPASS_EN
        check("x6_before_edge", read_data1, 32'h0000BBBB);
`else
        check("x6_before_edge", read_data1, 32'hAAAA0000);
`endif
        tick();
        reg_write = 1'b0;
        #1;
        check("x6_after_edge", read_data2, 32'h0000BBBB);

        // Write to x0 must not show up, bypass build included.
        reg_write = 1'b1; rd = 5'd0; write_data = 32'h12345678;
        rs1 = 5'd0; rs2 = 5'd0;
        #1;
        check("x0_same_cycle", read_data1, 32'h0);
        tick();
        reg_write = 1'b0;
        #1;
        check("x0_after_edge", read_data2, 32'h0);

        // Unknown rd with writes disabled leaves state intact.
        reg_write = 1'b0; rd = 5'bxxxxx; write_data = 32'hFFFFFFFF;
        tick();
        rd = 5'd0;
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            #1;
            check($sformatf("xrd_keep[%0d]", i), read_data1, (i == 0) ? 32'h0 : model[i]);
        end

        // Randomized traffic against the array model.
        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(0, 24) == 0);
            reg_write  = $urandom_range(0, 1) == 1;
            rd         = 5'($urandom_range(0, 31));
            write_data = $urandom;
            rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rs2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            #1;
            check($sformatf("rand%0d_rd1", n), read_data1, exp_rd(rs1));
            check($sformatf("rand%0d_rd2", n), read_data2, exp_rd(rs2));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
